// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with load formatting, stall/flush and retire counter
// Optional misaligned-load flag: define MEM_WB_MISALIGN_TRAP_EN to add misalign_o.
module mem_wb_stage #(
    parameter int DW         = 32,
    parameter int RW         = 5,
    parameter int ZERO_GUARD = 1
) (
    input  logic          reloj,
    input  logic          resetWB,
    input  logic          enableWB,
    input  logic          flushWB,
    input  logic          valid_i,
    input  logic          RegWrite_i,
    input  logic          MemtoReg_i,
    input  logic [1:0]    load_size_i,
    input  logic          load_unsigned_i,
    input  logic [DW-1:0] Y_ALU,
    input  logic [DW-1:0] DO_MEM,
    input  logic [RW-1:0] rd_i,
    output logic [RW-1:0] rd_o,
    output logic          RegWrite_o,
    output logic [DW-1:0] WB_data,
    output logic          valid_o,
`ifdef MEM_WB_MISALIGN_TRAP_EN
    output logic          misalign_o,
`endif
    output logic [31:0]   retire_cnt_o
);

    logic [7:0]    byte_lane;
    logic [15:0]   half_lane;
    logic [DW-1:0] load_data;
    logic [DW-1:0] wb_data_d;
    logic          misalign;
    logic          reg_write_d;
    logic          retire;

    logic [RW-1:0] rd_q;
    logic          reg_write_q;
    logic [DW-1:0] wb_data_q;
    logic          valid_q;
    logic          misalign_q;
    logic [31:0]   retire_q;

    always_comb begin
        byte_lane = DO_MEM[7:0];
        case (Y_ALU[1:0])
            2'd0: byte_lane = DO_MEM[7:0];
            2'd1: byte_lane = DO_MEM[15:8];
            2'd2: byte_lane = DO_MEM[23:16];
            2'd3: byte_lane = DO_MEM[31:24];
            default: byte_lane = DO_MEM[7:0];
        endcase
        half_lane = Y_ALU[1] ? DO_MEM[31:16] : DO_MEM[15:0];

        load_data = DO_MEM;
        case (load_size_i)
            2'b00: load_data = {{(DW-8){~load_unsigned_i & byte_lane[7]}}, byte_lane};
            2'b01: load_data = {{(DW-16){~load_unsigned_i & half_lane[15]}}, half_lane};
            default: load_data = DO_MEM;
        endcase
        wb_data_d = MemtoReg_i ? load_data : Y_ALU;
    end

`ifdef MEM_WB_MISALIGN_TRAP_EN
    // Size 2'b11 is handled as a word, so load_size_i[1] selects the word check.
    assign misalign = valid_i & MemtoReg_i &
                      (((load_size_i == 2'b01) & Y_ALU[0]) |
                       (load_size_i[1] & (Y_ALU[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign reg_write_d = RegWrite_i & valid_i & ~misalign &
                         ~((ZERO_GUARD != 0) && (rd_i == '0));
    assign retire      = valid_i & ~misalign;

    always_ff @(posedge reloj or negedge resetWB) begin
        if (!resetWB) begin
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_data_q   <= '0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
            retire_q    <= '0;
        end else if (flushWB) begin
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            wb_data_q   <= '0;
            valid_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else if (enableWB) begin
            rd_q        <= rd_i;
            reg_write_q <= reg_write_d;
            wb_data_q   <= wb_data_d;
            valid_q     <= valid_i;
            misalign_q  <= misalign;
            if (retire) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    assign rd_o         = rd_q;
    assign RegWrite_o   = reg_write_q;
    assign WB_data      = wb_data_q;
    assign valid_o      = valid_q;
    assign retire_cnt_o = retire_q;
`ifdef MEM_WB_MISALIGN_TRAP_EN
    assign misalign_o   = misalign_q;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage
module tb_mem_wb_stage;

    logic        reloj = 1'b0;
    logic        resetWB, enableWB, flushWB, valid_i, RegWrite_i, MemtoReg_i;
    logic [1:0]  load_size_i;
    logic        load_unsigned_i;
    logic [31:0] Y_ALU, DO_MEM;
    logic [4:0]  rd_i, rd_o;
    logic        RegWrite_o, valid_o;
    logic [31:0] WB_data, retire_cnt_o;
    logic        misalign_o;

    mem_wb_stage dut (
        .reloj(reloj), .resetWB(resetWB), .enableWB(enableWB), .flushWB(flushWB),
        .valid_i(valid_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
        .load_size_i(load_size_i), .load_unsigned_i(load_unsigned_i),
        .Y_ALU(Y_ALU), .DO_MEM(DO_MEM), .rd_i(rd_i),
        .rd_o(rd_o), .RegWrite_o(RegWrite_o), .WB_data(WB_data), .valid_o(valid_o),
`ifdef MEM_WB_MISALIGN_TRAP_EN
        .misalign_o(misalign_o),
`endif
        .retire_cnt_o(retire_cnt_o)
    );

`ifndef MEM_WB_MISALIGN_TRAP_EN
    assign misalign_o = 1'b0;
`endif

    always #5 reloj = ~reloj;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fmt(input logic [31:0] d, input logic [31:0] a,
                                        input logic [1:0] sz, input logic u);
        logic [31:0] x;
        x = d;
        if (sz == 2'b00) begin
            x = (d >> (8 * a[1:0])) & 32'h0000_00FF;
            if (!u && x[7]) x = x | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            x = (d >> (16 * a[1])) & 32'h0000_FFFF;
            if (!u && x[15]) x = x | 32'hFFFF_0000;
        end
        return x;
    endfunction

    task automatic drive(input logic en, input logic fl, input logic v, input logic rw,
                         input logic m2r, input logic [1:0] sz, input logic u,
                         input logic [31:0] y, input logic [31:0] dm, input logic [4:0] rd);
        logic mis;
        exp_t e;
        enableWB = en; flushWB = fl; valid_i = v; RegWrite_i = rw; MemtoReg_i = m2r;
        load_size_i = sz; load_unsigned_i = u; Y_ALU = y; DO_MEM = dm; rd_i = rd;
        mis = 1'b0;
`ifdef MEM_WB_MISALIGN_TRAP_EN
        mis = v && m2r && ((sz == 2'b01 && y[0]) || (sz >= 2'b10 && y[1:0] != 2'b00));
`endif
        if (fl) begin
            m.rd = '0; m.we = 1'b0; m.data = '0; m.valid = 1'b0; m.mis = 1'b0;
        end else if (en) begin
            m.rd    = rd;
            m.we    = rw && v && !mis && (rd != 5'd0);
            m.data  = m2r ? fmt(dm, y, sz, u) : y;
            m.valid = v;
            m.mis   = mis;
            if (v && !mis) m.cnt = m.cnt + 32'd1;
        end
        sb.push_back(m);
        @(posedge reloj);
        #1;
        e = sb.pop_front();
        check("rd",    {27'd0, rd_o},       {27'd0, e.rd});
        check("we",    {31'd0, RegWrite_o}, {31'd0, e.we});
        check("data",  WB_data,             e.data);
        check("valid", {31'd0, valid_o},    {31'd0, e.valid});
        check("cnt",   retire_cnt_o,        e.cnt);
`ifdef MEM_WB_MISALIGN_TRAP_EN
        check("mis",   {31'd0, misalign_o}, {31'd0, e.mis});
`endif
        @(negedge reloj);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd"},    {27'd0, rd_o},       32'd0);
        check({tag, "_we"},    {31'd0, RegWrite_o}, 32'd0);
        check({tag, "_data"},  WB_data,             32'd0);
        check({tag, "_valid"}, {31'd0, valid_o},    32'd0);
        check({tag, "_cnt"},   retire_cnt_o,        32'd0);
        check({tag, "_mis"},   {31'd0, misalign_o}, 32'd0);
    endtask

    initial begin
        m = '0;
        resetWB = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enableWB = 1'b1; flushWB = 1'b0; valid_i = 1'b1; RegWrite_i = 1'b1;
            MemtoReg_i = $urandom_range(0, 1); load_size_i = 2'($urandom_range(0, 3));
            load_unsigned_i = $urandom_range(0, 1); Y_ALU = $urandom; DO_MEM = $urandom;
            rd_i = 5'($urandom_range(1, 31));
            @(negedge reloj);
        end
        check_zero("reset");
        resetWB = 1'b1;

        // first edge after release must capture
        drive(1, 0, 1, 1, 1, 2'b00, 0, 32'h0000_1003, 32'h80FF_7F01, 5'd5);
        check("byte_s3", WB_data, 32'hFFFF_FF80);
        drive(1, 0, 1, 1, 1, 2'b00, 1, 32'h0000_1003, 32'h80FF_7F01, 5'd5);
        check("byte_u3", WB_data, 32'h0000_0080);
        drive(1, 0, 1, 1, 1, 2'b00, 0, 32'h0000_1001, 32'h80FF_7F01, 5'd6);
        check("byte_s1", WB_data, 32'h0000_007F);
        drive(1, 0, 1, 1, 1, 2'b01, 0, 32'h0000_2002, 32'h8001_ABCD, 5'd7);
        check("half_s2", WB_data, 32'hFFFF_8001);
        drive(1, 0, 1, 1, 1, 2'b10, 0, 32'h0000_2000, 32'h8001_ABCD, 5'd8);
        check("word", WB_data, 32'h8001_ABCD);
        drive(1, 0, 1, 1, 0, 2'b00, 0, 32'h1234_5678, 32'h8001_ABCD, 5'd9);
        check("alu", WB_data, 32'h1234_5678);
        drive(1, 0, 1, 1, 0, 2'b10, 0, 32'h0000_0040, 32'h0, 5'd0);
        check("zero_we", {31'd0, RegWrite_o}, 32'd0);
        check("zero_cnt", retire_cnt_o, 32'd7);
        drive(1, 0, 0, 1, 0, 2'b10, 0, 32'hCAFE_0000, 32'h0, 5'd3);

        for (int i = 0; i < 3; i++)
            drive(0, 0, 1, 1, 1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, 5'($urandom_range(1, 31)));
        drive(1, 1, 1, 1, 1, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd4);
        drive(0, 1, 1, 1, 1, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd4);

        for (int i = 0; i < 40; i++)
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom, $urandom,
                  5'($urandom_range(0, 31)));

`ifdef MEM_WB_MISALIGN_TRAP_EN
        drive(1, 0, 1, 1, 1, 2'b01, 0, 32'h0000_3001, 32'h8001_ABCD, 5'd10);
        check("mis_half", {31'd0, misalign_o}, 32'd1);
        drive(1, 0, 1, 1, 1, 2'b10, 0, 32'h0000_3002, 32'h8001_ABCD, 5'd11);
        check("mis_word", {31'd0, misalign_o}, 32'd1);
`endif

        // counter wrap: preset the count while stalled
        drive(0, 0, 1, 1, 1, 2'b10, 0, 32'h0, 32'h0, 5'd1);
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        m.cnt = 32'hFFFF_FFFF;
        #1;
        check("preset", retire_cnt_o, 32'hFFFF_FFFF);
        @(negedge reloj);
        drive(1, 0, 1, 1, 0, 2'b10, 0, 32'h0000_0055, 32'h0, 5'd12);
        check("wrap", retire_cnt_o, 32'd0);
        drive(1, 0, 1, 1, 0, 2'b10, 0, 32'h0000_0056, 32'h0, 5'd13);

        // asynchronous reset in the middle of a stall
        drive(0, 0, 1, 1, 1, 2'b10, 0, 32'h0, 32'h1111_2222, 5'd14);
        #3;
        resetWB = 1'b0;
        #1;
        check_zero("async");
        m = '0;
        @(negedge reloj);
        resetWB = 1'b1;
        drive(1, 0, 1, 1, 1, 2'b00, 1, 32'h0000_0002, 32'h00AB_0000, 5'd15);
        check("post_rst", WB_data, 32'h0000_00AB);

        if (sb.size() != 0) check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
